// File: rtl/imm_gen_pipe_pkg.sv
// rtl/imm_gen_pipe_pkg.sv - opcode constants and enums for the immediate generator
//
// Purpose : shared opcode encodings, shift-mode and FSM state enums used by
//           imm_decode and imm_gen_pipe.
// Ports   : none (package).

package imm_gen_pkg;

   localparam logic [3:0] OPC_UPPER  = 4'b0101;
   localparam logic [3:0] OPC_BRANCH = 4'b0110;
   localparam logic [3:0] OPC_ALU0   = 4'b1000;
   localparam logic [3:0] OPC_ALU1   = 4'b1001;
   localparam logic [3:0] OPC_ALU2   = 4'b1010;
   localparam logic [3:0] OPC_ALU3   = 4'b1011;
   localparam logic [3:0] OPC_ZEXT   = 4'b1111;
   localparam logic [3:0] OPC_PREFIX = 4'b1110;

   typedef enum logic [1:0] {
      SH_NONE,
      SH_ONE,
      SH_UPPER
   } shift_e;

   typedef enum logic {
      ST_IDLE,
      ST_PFX
   } state_e;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// rtl/imm_gen_pipe_if.sv - instruction-in / immediate-out handshake bundle
//
// Purpose : groups the input handshake, instruction word and output register
//           fields of the immediate generator.
// Ports   : in_valid/in_ready/inst     - instruction side
//           out_valid/out_ready        - result handshake
//           out/out_has_imm/out_opc/out_pfx_drop - result fields
// Modports: master - upstream/downstream environment, slave - the stage.

interface imm_gen_pipe_if #(
   parameter int XLEN  = 16,
   parameter int OPC_W = 4
);

   logic             in_valid;
   logic             in_ready;
   logic [XLEN-1:0]  inst;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out;
   logic             out_has_imm;
   logic [OPC_W-1:0] out_opc;
   logic             out_pfx_drop;

   modport master (
      output in_valid, inst, out_ready,
      input  in_ready, out_valid, out, out_has_imm, out_opc, out_pfx_drop
   );

   modport slave (
      input  in_valid, inst, out_ready,
      output in_ready, out_valid, out, out_has_imm, out_opc, out_pfx_drop
   );

endinterface

// File: rtl/imm_gen_pipe_decode.sv
// rtl/imm_gen_pipe_decode.sv - combinational immediate decode
//
// Purpose : maps opcode, immediate field and any pending prefix to the final
//           immediate value, plus has_imm / is_prefix classification.
// Ports   : opc, imm        - fields extracted from the instruction
//           pfx, pfx_valid  - latched upper bits and whether they apply
//           value           - extended, prefixed and shifted immediate
//           has_imm         - opcode carries an immediate
//           is_prefix       - opcode is the immediate prefix

module imm_decode
   import imm_gen_pkg::*;
#(
   parameter int XLEN  = 16,
   parameter int IMM_W = 8,
   parameter int OPC_W = 4
) (
   input  logic [OPC_W-1:0]      opc,
   input  logic [IMM_W-1:0]      imm,
   input  logic [XLEN-IMM_W-1:0] pfx,
   input  logic                  pfx_valid,
   output logic [XLEN-1:0]       value,
   output logic                  has_imm,
   output logic                  is_prefix
);

   localparam int PFX_W = XLEN - IMM_W;

   shift_e          sh;
   logic            zext;
   logic [XLEN-1:0] base;

   always_comb begin
      has_imm   = 1'b0;
      is_prefix = 1'b0;
      zext      = 1'b0;
      sh        = SH_NONE;
      case (opc)
         OPC_W'(OPC_UPPER): begin
            has_imm = 1'b1;
            sh      = SH_UPPER;
         end
         OPC_W'(OPC_BRANCH): begin
            has_imm = 1'b1;
            sh      = SH_ONE;
         end
         OPC_W'(OPC_ALU0), OPC_W'(OPC_ALU1),
         OPC_W'(OPC_ALU2), OPC_W'(OPC_ALU3): begin
            has_imm = 1'b1;
         end
         OPC_W'(OPC_ZEXT): begin
            has_imm = 1'b1;
            zext    = 1'b1;
         end
         OPC_W'(OPC_PREFIX): begin
            is_prefix = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // A pending prefix supplies the upper bits verbatim, so extension mode
   // only matters when no prefix is in flight.
   always_comb begin
      if (pfx_valid) begin
         base = {pfx, imm};
      end else if (zext) begin
         base = {{PFX_W{1'b0}}, imm};
      end else begin
         base = {{PFX_W{imm[IMM_W-1]}}, imm};
      end
   end

   always_comb begin
      value = '0;
      if (has_imm) begin
         case (sh)
            SH_UPPER: value = base << IMM_W;
            SH_ONE:   value = base << 1;
            default:  value = base;
         endcase
      end
   end

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - pipelined immediate generator with prefix support
//
// Purpose : accepts one instruction per cycle, decodes its immediate and
//           presents it from a single output register one cycle later.
//           PREFIX instructions latch upper bits for the next immediate.
// Ports   : clock  - rising-edge clock
//           reset  - synchronous, active-high
//           flush  - synchronous pipeline flush; drops output, prefix and
//                    any instruction offered in the same cycle
//           bus    - imm_gen_pipe_if.slave (instruction in, immediate out)

module imm_gen_pipe
   import imm_gen_pkg::*;
#(
   parameter int XLEN  = 16,
   parameter int IMM_W = 8,
   parameter int OPC_W = 4
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           flush,
   imm_gen_pipe_if.slave  bus
);

   localparam int PFX_W = XLEN - IMM_W;

   state_e             state_q;
   state_e             state_d;
   logic [PFX_W-1:0]   pfx_q;
   logic [PFX_W-1:0]   pfx_d;

   logic               out_valid_q;
   logic               out_valid_d;
   logic [XLEN-1:0]    out_q;
   logic               has_q;
   logic [OPC_W-1:0]   opc_q;
   logic               drop_q;
   logic               drop_d;
   logic               load_out;

   logic [IMM_W-1:0]   imm_f;
   logic [OPC_W-1:0]   opc_f;
   logic [PFX_W-1:0]   pfx_new;
   logic               unused_inst;

   logic [XLEN-1:0]    dec_value;
   logic               dec_has;
   logic               dec_prefix;

   logic               in_ready;
   logic               accept;

   assign imm_f       = bus.inst[XLEN-1 -: IMM_W];
   assign opc_f       = bus.inst[OPC_W-1:0];
   // Middle instruction bits carry register fields not used here.
   assign unused_inst = ^bus.inst;
   // Sign-extended immediate, truncated to the prefix width.
   assign pfx_new     = PFX_W'($signed(imm_f));

   imm_decode #(
      .XLEN  (XLEN),
      .IMM_W (IMM_W),
      .OPC_W (OPC_W)
   ) u_decode (
      .opc       (opc_f),
      .imm       (imm_f),
      .pfx       (pfx_q),
      .pfx_valid (state_q == ST_PFX),
      .value     (dec_value),
      .has_imm   (dec_has),
      .is_prefix (dec_prefix)
   );

   // Single output register: room exists when empty or draining this edge.
   assign in_ready = !out_valid_q || bus.out_ready;
   assign accept   = bus.in_valid && in_ready;

   always_comb begin
      state_d     = state_q;
      pfx_d       = pfx_q;
      out_valid_d = out_valid_q;
      load_out    = 1'b0;
      drop_d      = 1'b0;
      if (flush) begin
         state_d     = ST_IDLE;
         pfx_d       = '0;
         out_valid_d = 1'b0;
      end else begin
         if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
         end
         if (accept) begin
            if (dec_prefix) begin
               // A prefix occupies an input slot but produces no output.
               state_d = ST_PFX;
               pfx_d   = pfx_new;
            end else begin
               state_d     = ST_IDLE;
               pfx_d       = '0;
               load_out    = 1'b1;
               out_valid_d = 1'b1;
               drop_d      = (state_q == ST_PFX) && !dec_has;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         pfx_q   <= '0;
      end else begin
         state_q <= state_d;
         pfx_q   <= pfx_d;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_q       <= '0;
         has_q       <= 1'b0;
         opc_q       <= '0;
         drop_q      <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         if (load_out) begin
            out_q  <= dec_value;
            has_q  <= dec_has;
            opc_q  <= opc_f;
            drop_q <= drop_d;
         end
      end
   end

   assign bus.in_ready     = in_ready;
   assign bus.out_valid    = out_valid_q;
   assign bus.out          = out_q;
   assign bus.out_has_imm  = has_q;
   assign bus.out_opc      = opc_q;
   assign bus.out_pfx_drop = drop_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - self-checking bench for imm_gen_pipe

module tb_imm_gen_pipe;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic flush = 1'b0;

   imm_gen_pipe_if #(.XLEN(16), .OPC_W(4)) bus ();

   imm_gen_pipe #(
      .XLEN  (16),
      .IMM_W (8),
      .OPC_W (4)
   ) dut (
      .clock (clock),
      .reset (reset),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_err = 0;

   // Reference: {has_imm, value} from the opcode rules using plain integers.
   function automatic logic [16:0] model_out(input logic [15:0] w, input bit pon,
                                             input logic [7:0] p);
      int imm8;
      int opc;
      int base;
      int v;
      bit has;
      imm8 = int'(w[15:8]);
      opc  = int'(w[3:0]);
      has  = 1'b1;
      if (pon)            base = int'(p) * 256 + imm8;
      else if (opc == 15) base = imm8;
      else                base = (imm8 >= 128) ? imm8 - 256 : imm8;
      case (opc)
         5:                v = base * 256;
         6:                v = base * 2;
         8, 9, 10, 11, 15: v = base;
         default: begin
            v   = 0;
            has = 1'b0;
         end
      endcase
      return {has, v[15:0]};
   endfunction

   bit          m_init  = 1'b0;
   bit          m_valid = 1'b0;
   bit          m_has   = 1'b0;
   bit          m_drop  = 1'b0;
   bit          m_pon   = 1'b0;
   logic [15:0] m_out   = '0;
   logic [3:0]  m_opc   = '0;
   logic [7:0]  m_pfx   = '0;
   logic        m_rdy;
   logic [16:0] m_next;

   assign m_rdy  = !m_valid || bus.out_ready;
   assign m_next = model_out(bus.inst, m_pon, m_pfx);

   always @(posedge clock) begin
      if (reset) begin
         m_init  <= 1'b1;
         m_valid <= 1'b0;
         m_pon   <= 1'b0;
         m_pfx   <= '0;
         m_out   <= '0;
         m_has   <= 1'b0;
         m_opc   <= '0;
         m_drop  <= 1'b0;
      end else if (flush) begin
         m_valid <= 1'b0;
         m_pon   <= 1'b0;
         m_pfx   <= '0;
      end else begin
         if (m_valid && bus.out_ready) m_valid <= 1'b0;
         if (bus.in_valid && m_rdy) begin
            if (bus.inst[3:0] == 4'hE) begin
               m_pon <= 1'b1;
               m_pfx <= bus.inst[15:8];
            end else begin
               m_valid <= 1'b1;
               m_out   <= m_next[15:0];
               m_has   <= m_next[16];
               m_opc   <= bus.inst[3:0];
               m_drop  <= m_pon && !m_next[16];
               m_pon   <= 1'b0;
            end
         end
      end
   end

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, req, $time);
      end
   endtask

   always @(negedge clock) begin
      if (m_init) begin
         cmp("in_ready", 32'(bus.in_ready), 32'(m_rdy));
         cmp("out_valid", 32'(bus.out_valid), 32'(m_valid));
         if (m_valid) begin
            cmp("out", 32'(bus.out), 32'(m_out));
            cmp("out_has_imm", 32'(bus.out_has_imm), 32'(m_has));
            cmp("out_opc", 32'(bus.out_opc), 32'(m_opc));
            cmp("out_pfx_drop", 32'(bus.out_pfx_drop), 32'(m_drop));
         end
      end
   end

   logic [17:0] cap_q[$];

   always @(negedge clock) begin
      if (m_init && !reset && bus.out_valid === 1'b1 && bus.out_ready)
         cap_q.push_back({bus.out_has_imm, bus.out_pfx_drop, bus.out});
   end

   task automatic chk(input string nm, input logic [15:0] v, input logic h, input logic d);
      logic [17:0] e;
      logic [17:0] a;
      e = {h, d, v};
      n_cmp++;
      if (cap_q.size() == 0) begin
         n_err++;
         $display("FAIL %s: no output emitted, required out=%h has_imm=%b pfx_drop=%b",
                  nm, v, h, d);
      end else begin
         a = cap_q.pop_front();
         if (a !== e) begin
            n_err++;
            $display("FAIL %s: got out=%h has_imm=%b pfx_drop=%b, required out=%h has_imm=%b pfx_drop=%b",
                     nm, a[15:0], a[17], a[16], v, h, d);
         end
      end
   endtask

   task automatic chk_empty(input string nm);
      n_cmp++;
      if (cap_q.size() != 0) begin
         n_err++;
         $display("FAIL %s: %0d extra outputs, required 0", nm, cap_q.size());
      end
      cap_q.delete();
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic send(input logic [15:0] w);
      logic acc;
      acc          = 1'b0;
      bus.in_valid = 1'b1;
      bus.inst     = w;
      for (int k = 0; k < 20; k++) begin
         @(negedge clock);
         acc = bus.in_ready;
         @(posedge clock);
         #1;
         if (acc) break;
      end
      if (!acc) begin
         n_cmp++;
         n_err++;
         $display("FAIL send_timeout: inst %h not accepted, required acceptance within 20 cycles", w);
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic check_reset_state(input string nm);
      @(negedge clock);
      cmp({nm, "_out_valid"}, 32'(bus.out_valid), 32'd0);
      cmp({nm, "_out"}, 32'(bus.out), 32'd0);
      cmp({nm, "_has_imm"}, 32'(bus.out_has_imm), 32'd0);
      cmp({nm, "_opc"}, 32'(bus.out_opc), 32'd0);
      cmp({nm, "_pfx_drop"}, 32'(bus.out_pfx_drop), 32'd0);
      cmp({nm, "_in_ready"}, 32'(bus.in_ready), 32'd1);
      @(posedge clock);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.inst      = '0;
      bus.out_ready = 1'b1;
      reset         = 1'b1;
      flush         = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      check_reset_state("reset");

      send(16'hF005);
      send(16'h8006);
      send(16'h7F08);
      send(16'hFF0F);
      idle(3);
      chk("upper", 16'hF000, 1'b1, 1'b0);
      chk("branch_neg", 16'hFF00, 1'b1, 1'b0);
      chk("alu_pos", 16'h007F, 1'b1, 1'b0);
      chk("zext", 16'h00FF, 1'b1, 1'b0);
      chk_empty("basic_count");

      send(16'h120E);
      send(16'h3408);
      idle(3);
      chk("pfx_alu", 16'h1234, 1'b1, 1'b0);
      chk_empty("pfx_alu_count");

      send(16'h120E);
      send(16'h3406);
      idle(3);
      chk("pfx_branch", 16'h2468, 1'b1, 1'b0);
      chk_empty("pfx_branch_count");

      send(16'h120E);
      send(16'h560E);
      send(16'h3408);
      idle(3);
      chk("pfx_overwrite", 16'h5634, 1'b1, 1'b0);
      chk_empty("pfx_overwrite_count");

      send(16'h120E);
      send(16'h0001);
      idle(3);
      chk("pfx_drop", 16'h0000, 1'b0, 1'b1);
      chk_empty("pfx_drop_count");

      fork
         begin
            send(16'h0108);
            send(16'h0208);
            send(16'hFF06);
            send(16'h0305);
            send(16'h0408);
            send(16'h050F);
         end
         begin
            repeat (3) @(posedge clock);
            #1 bus.out_ready = 1'b0;
            repeat (3) @(posedge clock);
            #1 bus.out_ready = 1'b1;
         end
      join
      idle(3);
      chk("stream_0", 16'h0001, 1'b1, 1'b0);
      chk("stream_1", 16'h0002, 1'b1, 1'b0);
      chk("stream_2", 16'hFFFE, 1'b1, 1'b0);
      chk("stream_3", 16'h0300, 1'b1, 1'b0);
      chk("stream_4", 16'h0004, 1'b1, 1'b0);
      chk("stream_5", 16'h0005, 1'b1, 1'b0);
      chk_empty("stream_count");

      send(16'h120E);
      bus.in_valid = 1'b1;
      bus.inst     = 16'h3408;
      flush        = 1'b1;
      @(posedge clock);
      #1;
      flush        = 1'b0;
      bus.in_valid = 1'b0;
      idle(3);
      chk_empty("flush_drop");
      send(16'h3408);
      idle(3);
      chk("after_flush", 16'h0034, 1'b1, 1'b0);
      chk_empty("after_flush_count");

      bus.out_ready = 1'b0;
      send(16'h0208);
      idle(2);
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      check_reset_state("reset_stalled");
      bus.out_ready = 1'b1;
      cap_q.delete();

      send(16'h120E);
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      send(16'h3408);
      idle(3);
      chk("reset_mid_prefix", 16'h0034, 1'b1, 1'b0);
      chk_empty("reset_mid_prefix_count");

      idle(2);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Parametrised, pipelined immediate generator for the 16-bit core's decode stage. Extracts the immediate field from each instruction, applies sign/zero extension and per-opcode shift, and delivers it one cycle later through a valid/ready handshake. Adds an immediate-prefix opcode: it latches upper bits that are concatenated onto the next immediate-bearing instruction, so full-width constants load without a separate upper/lower pair.

## Interface
- XLEN, 16, instruction and immediate width
- IMM_W, 8, width of the immediate field at inst[XLEN-1 -: IMM_W]
- OPC_W, 4, width of the opcode field at inst[OPC_W-1:0]
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- flush  in  1  synchronous pipeline flush (mispredict)
- in_valid  in  1  inst is valid this cycle
- in_ready  out  1  stage can accept inst
- inst  in  XLEN  instruction word
- out_valid  out  1  out_* fields valid
- out_ready  in  1  consumer accepts output
- out  out  XLEN  generated immediate
- out_has_imm  out  1  opcode carries an immediate
- out_opc  out  OPC_W  opcode of the emitted instruction
- out_pfx_drop  out  1  pending prefix was discarded by this instruction

## Operation
- ext(x) = sign-extend IMM_W to XLEN; zext(x) = zero-extend.
- Opcodes: 0101 upper: ext(imm) << IMM_W. 0110 branch: ext(imm) << 1. 1000–1011 ALU-imm/load/store: ext(imm). 1111 zext(imm). 1110 PREFIX. All others: out_has_imm=0, out=0.
- State machine, two states:
  - IDLE: PREFIX accepted -> pfx <= ext(imm) truncated to XLEN-IMM_W; goto PFX; no output produced.
  - PFX: imm-bearing opcode accepted -> base = {pfx, imm} replaces the extended value; the opcode's shift is still applied, truncated to XLEN; goto IDLE. PREFIX accepted -> pfx overwritten; stay in PFX. Non-imm opcode accepted -> emitted normally with out_pfx_drop=1; goto IDLE.
- Handshake: transfer on in_valid & in_ready. in_ready = !out_valid | out_ready (single output register, no bubble under continuous flow). Output fields hold stable while out_valid & !out_ready.
- PREFIX consumes an input slot; out_valid in the following cycle reflects only the output-register drain.
- flush: out_valid <= 0, state <= IDLE, pfx cleared; any input offered in the same cycle is dropped; flush overrides reset-free transfer.
- Reset: out_valid=0, out=0, out_has_imm=0, out_opc=0, out_pfx_drop=0, state IDLE, pfx=0. Reset mid-prefix discards the prefix with no drop indication.

## Timing
- Latency: 1 cycle from accepted inst to out_valid.
- Throughput: 1 inst/cycle while out_ready=1.
- Stall: out_ready=0 with out_valid=1 -> in_ready=0; state and pfx frozen.
- Simultaneous drain and accept: the new result loads in the same edge the old one leaves.
- in_ready is combinational from out_valid/out_ready only; it never depends on inst.

## Structure
- Package imm_gen_pkg: opcode localparams (OPC_UPPER=0101, OPC_BRANCH=0110, OPC_ALU0..3=1000–1011, OPC_ZEXT=1111, OPC_PREFIX=1110), shift-mode enum {SH_NONE, SH_ONE, SH_UPPER}, state enum {ST_IDLE, ST_PFX}.
- Sub-module imm_decode: combinational; maps opcode, imm, pfx and pfx_valid to {value, has_imm, is_prefix}. The top level holds the FSM, pfx register, output register and handshake.

## Test plan
- Reset, then 16'hF005 -> out=16'hF000, out_has_imm=1 one cycle later; 16'h8006 -> 16'hFF00; 16'h7F08 -> 16'h007F; 16'hFF0F -> 16'h00FF.
- 16'h120E then 16'h3408 -> single output out=16'h1234; 16'h120E then 16'h3406 -> out=16'h2468.
- 16'h120E, 16'h560E, 16'h3408 -> out=16'h5634 (prefix overwrite); 16'h120E then 16'h0001 -> out=0, out_has_imm=0, out_pfx_drop=1.
- Back-to-back stream with out_ready held low 3 cycles mid-stream -> in_ready=0, outputs stable, no loss or duplication, order preserved.
- 16'h120E, then flush asserted with 16'h3408 offered -> nothing emitted; next 16'h3408 -> out=16'h0034.
- reset asserted while in PFX with out_valid=1 -> next cycle all outputs 0, in_ready=1, subsequent 16'h3408 -> 16'h0034.
